// File: rtl/pair_issuer_pkg.sv
// rtl/pair_issuer_pkg.sv - shared widths, constants and FSM states for the pair issuer
package pair_issuer_pkg;
   localparam int FLOAT_W = 32;
   localparam int POS_W   = 3 * FLOAT_W;
   localparam int ADDR_W  = 4;
   localparam logic [FLOAT_W-1:0] BOX_LEN = 32'h40F00000;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/pair_fifo.sv
// rtl/pair_fifo.sv - two-entry synchronous FIFO holding issued particle pairs
module pair_fifo #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic [1:0]   count
);
   logic [W-1:0] mem0, mem1;
   logic         wr_sel, rd_sel;

   assign dout = rd_sel ? mem1 : mem0;

   always_ff @(posedge clk) begin
      if (rst) begin
         mem0   <= '0;
         mem1   <= '0;
         wr_sel <= 1'b0;
         rd_sel <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            if (wr_sel) mem1 <= din;
            else        mem0 <= din;
            wr_sel <= ~wr_sel;
         end
         if (pop) rd_sel <= ~rd_sel;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end
endmodule

// File: rtl/pair_issuer.sv
// rtl/pair_issuer.sv - walks two cell position memories and streams every (reference, neighbour) pair
module pair_issuer #(
   parameter int ADDR_W = pair_issuer_pkg::ADDR_W,
   parameter int DATA_W = pair_issuer_pkg::POS_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W:0]   ref_count,
   input  logic [ADDR_W:0]   nbr_count,
   input  logic              same_cell,
   output logic              rd_en,
   output logic [ADDR_W-1:0] ref_addr,
   output logic [ADDR_W-1:0] nbr_addr,
   input  logic [DATA_W-1:0] ref_rdata,
   input  logic [DATA_W-1:0] nbr_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_reference,
   output logic [DATA_W-1:0] out_neighbor,
   output logic [ADDR_W-1:0] out_ref_idx,
   output logic [ADDR_W-1:0] out_nbr_idx,
   output logic              busy,
   output logic              done
);
   import pair_issuer_pkg::*;

   localparam int CW = ADDR_W + 2;
   localparam int FW = 2 * DATA_W + 2 * ADDR_W;
   localparam logic [CW-1:0]   ONE     = CW'(1);
   localparam logic [CW-1:0]   TWO     = CW'(2);
   localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

   state_t            state;
   logic [CW-1:0]     i, j, i_lim, j_lim;
   logic              same, inflight, settle;
   logic              pop, row_end, last, empty, drain_ok;
   logic [ADDR_W-1:0] cap_i, cap_j;
   logic [1:0]        count;
   logic [FW-1:0]     head;

   assign pop       = out_valid & out_ready;
   assign out_valid = (count != 2'd0);
   // Occupancy counts the read already in flight so the FIFO can never overflow.
   assign rd_en     = (state == RUN) &&
                      (({1'b0, count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
   assign ref_addr  = i[ADDR_W-1:0];
   assign nbr_addr  = j[ADDR_W-1:0];

   assign row_end  = (j + ONE >= j_lim);
   assign last     = row_end && (same ? (i + TWO >= i_lim) : (i + ONE >= i_lim));
   assign empty    = same_cell ? (ref_count <= CNT_ONE)
                               : ((ref_count == '0) || (nbr_count == '0));
   assign drain_ok = !settle && !inflight && (count == {1'b0, pop});

   assign out_reference = head[FW-1 -: DATA_W];
   assign out_neighbor  = head[FW-DATA_W-1 -: DATA_W];
   assign out_ref_idx   = head[2*ADDR_W-1 -: ADDR_W];
   assign out_nbr_idx   = head[ADDR_W-1:0];

   pair_fifo #(.W(FW)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (inflight),
      .din   ({ref_rdata, nbr_rdata, cap_i, cap_j}),
      .pop   (pop),
      .dout  (head),
      .count (count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         i        <= '0;
         j        <= '0;
         i_lim    <= '0;
         j_lim    <= '0;
         same     <= 1'b0;
         inflight <= 1'b0;
         settle   <= 1'b0;
         cap_i    <= '0;
         cap_j    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         inflight <= rd_en;
         done     <= 1'b0;
         if (rd_en) begin
            cap_i <= i[ADDR_W-1:0];
            cap_j <= j[ADDR_W-1:0];
         end
         case (state)
            IDLE: begin
               if (start) begin
                  busy   <= 1'b1;
                  settle <= 1'b1;
                  if (empty) begin
                     state <= DRAIN;
                  end else begin
                     state <= RUN;
                     i     <= '0;
                     j     <= same_cell ? ONE : '0;
                     i_lim <= {1'b0, ref_count};
                     j_lim <= same_cell ? {1'b0, ref_count} : {1'b0, nbr_count};
                     same  <= same_cell;
                  end
               end
            end
            RUN: begin
               // Counters stop on the final pair so the addresses hold after the sweep.
               if (rd_en) begin
                  if (last) begin
                     state  <= DRAIN;
                     settle <= 1'b1;
                  end else if (row_end) begin
                     i <= i + ONE;
                     j <= same ? (i + TWO) : '0;
                  end else begin
                     j <= j + ONE;
                  end
               end
            end
            DRAIN: begin
               settle <= 1'b0;
               if (drain_ok) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pair_issuer.sv
// tb/tb_pair_issuer.sv - directed self-checking bench for pair_issuer
module tb_pair_issuer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [4:0]  ref_count = '0;
   logic [4:0]  nbr_count = '0;
   logic        same_cell = 1'b0;
   logic        rd_en;
   logic [3:0]  ref_addr, nbr_addr;
   logic [95:0] ref_rdata = '0;
   logic [95:0] nbr_rdata = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [95:0] out_reference, out_neighbor;
   logic [3:0]  out_ref_idx, out_nbr_idx;
   logic        busy, done;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];
   int cyc = 0, start_cyc = 0, first_rd_cyc = -1, first_val_cyc = -1;
   int done_cyc = 0, done_cnt = 0, pops = 0, occ = 0;
   logic infl = 1'b0, prev_stall = 1'b0, p;
   logic [199:0] prev_payload = '0;
   logic [7:0] e;
   logic [3:0] pat = 4'b1001;

   wire [199:0] payload = {out_ref_idx, out_nbr_idx, out_reference, out_neighbor};

   always #5 clk = ~clk;

   pair_issuer dut (
      .clk(clk), .rst(rst), .start(start), .ref_count(ref_count), .nbr_count(nbr_count),
      .same_cell(same_cell), .rd_en(rd_en), .ref_addr(ref_addr), .nbr_addr(nbr_addr),
      .ref_rdata(ref_rdata), .nbr_rdata(nbr_rdata), .out_valid(out_valid), .out_ready(out_ready),
      .out_reference(out_reference), .out_neighbor(out_neighbor), .out_ref_idx(out_ref_idx),
      .out_nbr_idx(out_nbr_idx), .busy(busy), .done(done)
   );

   // Position memories: reference word k = k, neighbour word k = k + 0x100.
   always @(posedge clk) begin
      if (rd_en) begin
         ref_rdata <= {92'b0, ref_addr};
         nbr_rdata <= {92'b0, nbr_addr} + 96'h100;
      end
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [199:0] exp_payload(input logic [3:0] a, input logic [3:0] b);
      return {a, b, {92'b0, a}, {92'b0, b} + 96'h100};
   endfunction

   // Monitor samples one time unit before each rising edge.
   always @(negedge clk) begin
      #4;
      cyc++;
      if (rst) begin
         occ = 0;
         infl = 1'b0;
         prev_stall = 1'b0;
      end else begin
         p = out_valid && out_ready;
         if (start && !busy) begin
            start_cyc = cyc;
            first_rd_cyc = -1;
            first_val_cyc = -1;
         end
         if (rd_en && first_rd_cyc < 0) first_rd_cyc = cyc;
         if (out_valid && first_val_cyc < 0) first_val_cyc = cyc;
         if (done) begin
            done_cyc = cyc;
            done_cnt++;
         end
         if (rd_en) chk("rd_en_occupancy", (occ + int'(infl) - int'(p)) < 2, 1);
         if (prev_stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_payload", payload, prev_payload);
         end
         if (p) begin
            chk("pair_present", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("pair", payload, exp_payload(e[7:4], e[3:0]));
            end
            pops++;
         end
         occ = occ + int'(infl) - int'(p);
         infl = rd_en;
         prev_stall = out_valid && !out_ready;
         prev_payload = payload;
      end
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_rd_en"}, rd_en, 0);
      chk({tag, "_addr"}, {ref_addr, nbr_addr}, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_payload"}, payload, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
   endtask

   task automatic do_start(input int rc, input int nc, input logic sc);
      @(negedge clk);
      pops = 0;
      for (int a = 0; a < rc; a++) begin
         if (sc) begin
            for (int b = a + 1; b < rc; b++) exp_q.push_back({4'(a), 4'(b)});
         end else begin
            for (int b = 0; b < nc; b++) exp_q.push_back({4'(a), 4'(b)});
         end
      end
      ref_count = 5'(rc);
      nbr_count = 5'(nc);
      same_cell = sc;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_sweep(input int mode, input int budget, input int stop_pops, input int d0);
      for (int k = 0; k < budget; k++) begin
         if (done_cnt != d0) break;
         if (stop_pops > 0 && pops >= stop_pops) break;
         if (mode == 1) out_ready = (k < 200) ? pat[k % 4] : 1'($urandom_range(0, 1));
         else out_ready = 1'b1;
         if (mode == 2 && k == 1) begin
            start = 1'b1;
            ref_count = 5'd4;
            same_cell = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic finish_sweep(input string tag, input int npairs, input int lat, input int d0);
      chk({tag, "_done_count"}, done_cnt - d0, 1);
      chk({tag, "_pairs"}, pops, npairs);
      chk({tag, "_left"}, exp_q.size(), 0);
      if (lat >= 0) chk({tag, "_done_latency"}, done_cyc - start_cyc - 1, lat);
      repeat (3) @(negedge clk);
      chk({tag, "_idle_busy"}, busy, 0);
      chk({tag, "_no_extra_done"}, done_cnt - d0, 1);
   endtask

   int d0;

   initial begin
      repeat (2) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      d0 = done_cnt;
      do_start(3, 2, 1'b0);
      run_sweep(0, 100, 0, d0);
      chk("diff_first_rd", first_rd_cyc - start_cyc, 1);
      chk("diff_first_valid", first_val_cyc - start_cyc, 3);
      finish_sweep("diff3x2", 6, 8, d0);

      d0 = done_cnt;
      do_start(4, 9, 1'b1);
      run_sweep(0, 100, 0, d0);
      finish_sweep("same4", 6, 8, d0);

      d0 = done_cnt;
      do_start(0, 5, 1'b0);
      run_sweep(0, 50, 0, d0);
      chk("empty0_no_valid", first_val_cyc, -1);
      finish_sweep("empty0", 0, 2, d0);

      d0 = done_cnt;
      do_start(1, 7, 1'b1);
      run_sweep(0, 50, 0, d0);
      chk("empty1_no_valid", first_val_cyc, -1);
      finish_sweep("empty1", 0, 2, d0);

      d0 = done_cnt;
      do_start(16, 16, 1'b0);
      run_sweep(1, 3000, 0, d0);
      finish_sweep("bp16x16", 256, -1, d0);

      d0 = done_cnt;
      do_start(3, 2, 1'b0);
      run_sweep(2, 100, 0, d0);
      finish_sweep("restart_ignored", 6, 8, d0);

      d0 = done_cnt;
      do_start(16, 16, 1'b0);
      run_sweep(0, 100, 5, d0);
      chk("midrst_pops", pops, 5);
      rst = 1'b1;
      @(negedge clk);
      chk_zero("midrst");
      rst = 1'b0;
      exp_q.delete();
      repeat (4) @(negedge clk);
      chk("midrst_no_done", done_cnt, d0);
      chk("midrst_valid_low", out_valid, 0);

      d0 = done_cnt;
      do_start(2, 3, 1'b0);
      run_sweep(0, 100, 0, d0);
      finish_sweep("after_rst", 6, 8, d0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
